// File: rtl/pll_led_pkg.sv
// pll_led_pkg: shared FSM/display types and pattern helpers for pll_led_supervisor.
package pll_led_pkg;

    typedef enum logic [1:0] {
        PLL_RST   = 2'd0,
        WAIT_LOCK = 2'd1,
        RUN       = 2'd2,
        FAULT     = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        ALL   = 2'd0,
        CHASE = 2'd1,
        COUNT = 2'd2
    } mode_t;

    localparam int MODE_COUNT = 3;

    // Pattern a mode starts from: one-hot bit 0 for CHASE, dark for the others.
    function automatic logic [31:0] mode_init(input mode_t m);
        return (m == CHASE) ? 32'd1 : 32'd0;
    endfunction

    // Button order ALL -> CHASE -> COUNT -> ALL.
    function automatic mode_t mode_next(input mode_t m);
        if (int'(m) >= MODE_COUNT - 1) begin
            return ALL;
        end
        return mode_t'(m + 2'd1);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: two-flop synchroniser, stability counter and rising-edge press pulse
// for an asynchronous active-high button.
module btn_debounce #(
    parameter int DEBOUNCE_CYC = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

    logic          sync_a;
    logic          sync_b;
    logic          level;
    logic [CW-1:0] cnt;

    // Accept a new level once the synced button has differed from it for DEBOUNCE_CYC cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
            level  <= 1'b0;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            sync_a <= btn;
            sync_b <= sync_a;
            press  <= 1'b0;
            if (sync_b == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sync_b;
                cnt   <= '0;
                press <= sync_b;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/pll_led_supervisor.sv
// pll_led_supervisor: PLL reset/lock supervisor with a button-selected N-LED display.
// Optional LED_PWM_EN adds PWM_DUTY and dims the RUN display with an 8-bit PWM counter.
module pll_led_supervisor
    import pll_led_pkg::*;
#(
    parameter int NUM_LEDS     = 4,
    parameter int PLL_RST_CYC  = 1000,
    parameter int LOCK_STABLE  = 256,
    parameter int LOCK_TIMEOUT = 100000,
    parameter int MAX_RETRY    = 3,
    parameter int DEBOUNCE_CYC = 50000,
    parameter int TICK_DIV     = 12000000
`ifdef LED_PWM_EN
    ,
    parameter logic [7:0] PWM_DUTY = 8'd64
`endif
) (
    input  logic                sys_CLK,
    input  logic                sys_RSTN,
    input  logic                pll_LOCKED,
    input  logic                btn1,
    output logic                pll_RSTN,
    output logic [NUM_LEDS-1:0] led,
    output logic                locked_ok,
    output logic                fault
);

    localparam int PH_MAX = (PLL_RST_CYC > LOCK_TIMEOUT) ? PLL_RST_CYC : LOCK_TIMEOUT;
    localparam int PH_W   = $clog2(PH_MAX + 1);
    localparam int ST_W   = $clog2(LOCK_STABLE + 1);
    localparam int RT_W   = $clog2(MAX_RETRY + 1);
    localparam int PS_W   = $clog2(TICK_DIV + 1);

    localparam logic [PH_W-1:0] RST_LAST    = PH_W'(PLL_RST_CYC - 1);
    localparam logic [PH_W-1:0] TO_LAST     = PH_W'(LOCK_TIMEOUT - 1);
    localparam logic [ST_W-1:0] STABLE_LAST = ST_W'(LOCK_STABLE - 1);
    localparam logic [RT_W-1:0] RETRY_MAX   = RT_W'(MAX_RETRY);
    localparam logic [PS_W-1:0] TICK_LAST   = PS_W'(TICK_DIV - 1);

    state_t              state, state_n;
    mode_t               mode, mode_n;
    logic [PH_W-1:0]     phase_cnt, phase_n;
    logic [ST_W-1:0]     stable_cnt, stable_n;
    logic [RT_W-1:0]     retry, retry_n;
    logic [PS_W-1:0]     presc, presc_n;
    logic [NUM_LEDS-1:0] pattern, pattern_n, pattern_adv, run_led;
    logic                lock_meta, lock_sync;
    logic                press, tick, run_stay;

    btn_debounce #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_btn (
        .clk  (sys_CLK),
        .rst_n(sys_RSTN),
        .btn  (btn1),
        .press(press)
    );

    // Bring the asynchronous PLL lock into the reference clock domain.
    always_ff @(posedge sys_CLK) begin
        if (!sys_RSTN) begin
            lock_meta <= 1'b0;
            lock_sync <= 1'b0;
        end else begin
            lock_meta <= pll_LOCKED;
            lock_sync <= lock_meta;
        end
    end

    // Supervisor and display state registers.
    always_ff @(posedge sys_CLK) begin
        if (!sys_RSTN) begin
            state      <= PLL_RST;
            phase_cnt  <= '0;
            stable_cnt <= '0;
            retry      <= '0;
            mode       <= ALL;
            pattern    <= '0;
            presc      <= '0;
        end else begin
            state      <= state_n;
            phase_cnt  <= phase_n;
            stable_cnt <= stable_n;
            retry      <= retry_n;
            mode       <= mode_n;
            pattern    <= pattern_n;
            presc      <= presc_n;
        end
    end

    // Reset/lock sequencing: timed PLL reset, stable-lock qualification, bounded retries.
    always_comb begin
        state_n  = state;
        phase_n  = phase_cnt + PH_W'(1);
        stable_n = stable_cnt;
        retry_n  = retry;
        case (state)
            PLL_RST: begin
                if (phase_cnt == RST_LAST) begin
                    state_n  = WAIT_LOCK;
                    phase_n  = '0;
                    stable_n = '0;
                end
            end
            WAIT_LOCK: begin
                stable_n = lock_sync ? stable_cnt + ST_W'(1) : '0;
                // A lock that qualifies on the timeout cycle still counts as success.
                if (lock_sync && (stable_cnt == STABLE_LAST)) begin
                    state_n  = RUN;
                    retry_n  = '0;
                    phase_n  = '0;
                    stable_n = '0;
                end else if (phase_cnt == TO_LAST) begin
                    retry_n  = retry + RT_W'(1);
                    phase_n  = '0;
                    stable_n = '0;
                    state_n  = (retry_n < RETRY_MAX) ? PLL_RST : FAULT;
                end
            end
            RUN: begin
                phase_n = '0;
                if (!lock_sync) begin
                    state_n = PLL_RST;
                end
            end
            FAULT: begin
                phase_n = '0;
            end
            default: begin
                state_n = PLL_RST;
                phase_n = '0;
            end
        endcase
    end

    assign run_stay = (state == RUN) && (state_n == RUN);

    // Display prescaler, mode selection and pattern stepping while RUN holds.
    always_comb begin
        tick        = 1'b0;
        presc_n     = '0;
        mode_n      = mode;
        pattern_n   = pattern;
        pattern_adv = pattern;
        case (mode)
            ALL:     pattern_adv = ~pattern;
            CHASE:   pattern_adv = {pattern[NUM_LEDS-2:0], pattern[NUM_LEDS-1]};
            COUNT:   pattern_adv = pattern + NUM_LEDS'(1);
            default: pattern_adv = pattern;
        endcase
        if (run_stay) begin
            tick    = (presc == TICK_LAST);
            presc_n = tick ? '0 : presc + PS_W'(1);
            // A press overrides a coincident tick: restart the new mode's pattern.
            if (press) begin
                mode_n    = mode_next(mode);
                pattern_n = NUM_LEDS'(mode_init(mode_n));
            end else if (tick) begin
                pattern_n = pattern_adv;
            end
        end else if (state_n == RUN) begin
            pattern_n = NUM_LEDS'(mode_init(mode));
        end
    end

`ifdef LED_PWM_EN
    logic [7:0] pwm_cnt;
    logic       pwm_on;

    // Free-running PWM phase for dimming the RUN display.
    always_ff @(posedge sys_CLK) begin
        if (!sys_RSTN) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 8'd1;
        end
    end

    assign pwm_on  = (pwm_cnt < PWM_DUTY);
    assign run_led = pattern & {NUM_LEDS{pwm_on}};
`else
    assign run_led = pattern;
`endif

    assign pll_RSTN  = (state != PLL_RST);
    assign locked_ok = (state == RUN);
    assign fault     = (state == FAULT);

    // LED bank: pattern in RUN, solid on in FAULT, dark while sequencing.
    always_comb begin
        led = '0;
        case (state)
            RUN:     led = run_led;
            FAULT:   led = '1;
            default: led = '0;
        endcase
    end

endmodule
